// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Imported by the arbiter top and its starvation counter.
package rf_arb_pkg;

  localparam int CNT_W = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STALL = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

  function automatic rf_wr_t wr_pick(
    input logic        we,
    input logic [4:0]  addr,
    input logic [31:0] data
  );
    rf_wr_t w;
    w.we   = we;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle between WB stage, MD unit, decode and the RF write port.
// The arbiter takes the slave view; its environment drives master.
interface rf_write_arbiter_if;

  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_req;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_grant;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        raw_hazard;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output wb_we, wb_addr, wb_data,
    output md_req, md_addr, md_data,
    output rd_addr1, rd_addr2,
    input  md_grant, raw_hazard, stall,
    input  rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  md_req, md_addr, md_data,
    input  rd_addr1, rd_addr2,
    output md_grant, raw_hazard, stall,
    output rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/rf_starve_counter.sv
// Saturating count of cycles an MD result has been denied the port.
// hit flags that one more denial reaches LIMIT.
module rf_starve_counter
  import rf_arb_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hit     = (cnt_nxt == (CNT_W+1)'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !cnt_nxt[CNT_W]) begin
      cnt <= cnt_nxt[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between WB and the multiply/divide unit.
// WB wins contested cycles; a starved MD result forces a drain stall.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  arb_state_e state_q;
  arb_state_e state_d;
  rf_wr_t     wr;
  logic       wb_valid;
  logic       md_valid;
  logic       same_dst;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       hit;
  logic       grant;

  assign wb_valid = bus.wb_we && (bus.wb_addr != REG_ZERO);
  assign md_valid = bus.md_req && (bus.md_addr != REG_ZERO);
  assign same_dst = (bus.md_addr == bus.wb_addr);

  rf_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .hit   (hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    cnt_inc = 1'b0;
    cnt_clr = 1'b1;
    grant   = 1'b0;
    wr      = wr_pick(wb_valid, bus.wb_addr, bus.wb_data);
    unique case (state_q)
      STALL: begin
        // frozen WB instruction replays after the stall
        wr    = wr_pick(md_valid, bus.md_addr, bus.md_data);
        grant = 1'b1;
      end
      IDLE, WAIT: begin
        if (bus.md_req) begin
          if (!wb_valid) begin
            wr    = wr_pick(md_valid, bus.md_addr, bus.md_data);
            grant = 1'b1;
          end else if (same_dst) begin
            // younger WB result overwrites; MD value is dead
            grant = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            cnt_clr = 1'b0;
            state_d = hit ? STALL : WAIT;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.md_grant   = grant;
  assign bus.stall      = (state_q == STALL);
  assign bus.rf_we      = wr.we;
  assign bus.rf_addr    = wr.addr;
  assign bus.rf_data    = wr.data;
  assign bus.raw_hazard = md_valid &&
                          ((bus.rd_addr1 == bus.md_addr) ||
                           (bus.rd_addr2 == bus.md_addr));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scoreboard bench for rf_write_arbiter.
// Expectations are queued on drive and checked at the falling edge.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        grant;
    logic        haz;
    logic        stall;
  } exp_t;

  exp_t sb[$];

  rf_write_arbiter_if bus();

  rf_write_arbiter #(
    .STARVE_LIMIT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drv(
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic        mr,
    input logic [4:0]  ma,
    input logic [31:0] md,
    input logic [4:0]  r1,
    input logic [4:0]  r2
  );
    bus.wb_we    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.md_req   = mr;
    bus.md_addr  = ma;
    bus.md_data  = md;
    bus.rd_addr1 = r1;
    bus.rd_addr2 = r2;
  endtask

  task automatic push(
    input string       tag,
    input logic        we,
    input logic [4:0]  addr,
    input logic [31:0] data,
    input logic        grant,
    input logic        haz,
    input logic        stall
  );
    exp_t e;
    e.tag   = tag;
    e.we    = we;
    e.addr  = addr;
    e.data  = data;
    e.grant = grant;
    e.haz   = haz;
    e.stall = stall;
    sb.push_back(e);
  endtask

  task automatic cmp(
    input string       tag,
    input string       fld,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h",
             tag, fld, obs, exp);
    end
  endtask

  task automatic chk_now();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, "rf_we", 32'(bus.rf_we), 32'(e.we));
    cmp(e.tag, "rf_addr", 32'(bus.rf_addr), 32'(e.addr));
    cmp(e.tag, "rf_data", bus.rf_data, e.data);
    cmp(e.tag, "md_grant", 32'(bus.md_grant), 32'(e.grant));
    cmp(e.tag, "raw_hazard", 32'(bus.raw_hazard), 32'(e.haz));
    cmp(e.tag, "stall", 32'(bus.stall), 32'(e.stall));
  endtask

  task automatic chk();
    @(negedge clk);
    chk_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0);
    chk();
    reset = 1'b1;

    // uncontested MD write
    drv(0, 0, 0, 1, 8, 32'hDEAD0001, 0, 0);
    push("md_free", 1, 8, 32'hDEAD0001, 1, 0, 0);
    chk();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    push("md_free_done", 0, 0, 0, 0, 0, 0);
    chk();

    // starvation: WB to r5 every cycle, MD to r9 waiting
    for (int i = 0; i < 3; i++) begin
      drv(1, 5, 32'hA5A50000 + 32'(i), 1, 9, 32'h99990009, 0, 0);
      push("starve_wait", 1, 5, 32'hA5A50000 + 32'(i), 0, 0, 0);
      chk();
    end
    drv(1, 5, 32'hA5A50003, 1, 9, 32'h99990009, 0, 0);
    push("starve_stall", 1, 9, 32'h99990009, 1, 0, 1);
    chk();
    drv(1, 5, 32'hA5A50004, 0, 0, 0, 0, 0);
    push("starve_after", 1, 5, 32'hA5A50004, 0, 0, 0);
    chk();

    // same destination: WB wins, MD discarded
    drv(1, 12, 32'h12121212, 1, 12, 32'h34343434, 0, 0);
    push("same_dst", 1, 12, 32'h12121212, 1, 0, 0);
    chk();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    push("same_dst_gone", 0, 0, 0, 0, 0, 0);
    chk();
    push("same_dst_gone2", 0, 0, 0, 0, 0, 0);
    chk();

    // register zero
    drv(0, 0, 0, 1, 0, 32'h00000055, 0, 0);
    push("md_r0", 0, 0, 32'h00000055, 1, 0, 0);
    chk();
    drv(1, 0, 32'h00000066, 0, 0, 0, 0, 0);
    push("wb_r0", 0, 0, 32'h00000066, 0, 0, 0);
    chk();

    // hazard, held pending behind WB to r4
    drv(1, 4, 32'h44, 1, 17, 32'h1717, 0, 17);
    push("haz_rd2", 1, 4, 32'h44, 0, 1, 0);
    chk();
    drv(1, 4, 32'h44, 1, 17, 32'h1717, 3, 3);
    push("haz_none", 1, 4, 32'h44, 0, 0, 0);
    chk();
    // request withdrawn in WAIT clears the wait
    drv(1, 4, 32'h45, 0, 17, 32'h1717, 17, 17);
    push("md_drop", 1, 4, 32'h45, 0, 0, 0);
    chk();
    drv(1, 4, 32'h46, 1, 18, 32'h1818, 18, 0);
    push("drop_cleared", 1, 4, 32'h46, 0, 1, 0);
    chk();
    drv(0, 0, 0, 1, 18, 32'h1818, 0, 0);
    push("drop_drain", 1, 18, 32'h1818, 1, 0, 0);
    chk();

    // reset in STALL
    for (int i = 0; i < 3; i++) begin
      drv(1, 5, 32'h50 + 32'(i), 1, 9, 32'h90, 0, 0);
      push("rst_wait", 1, 5, 32'h50 + 32'(i), 0, 0, 0);
      chk();
    end
    drv(1, 5, 32'h53, 1, 9, 32'h90, 0, 0);
    push("rst_stall", 1, 9, 32'h90, 1, 0, 1);
    @(negedge clk);
    chk_now();
    #2;
    reset = 1'b0;
    #1;
    push("rst_async", 1, 5, 32'h53, 0, 0, 0);
    chk_now();
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    push("rst_idle", 0, 0, 0, 0, 0, 0);
    chk();
    reset = 1'b1;

    // counter restarted from zero
    for (int i = 0; i < 3; i++) begin
      drv(1, 6, 32'h60 + 32'(i), 1, 10, 32'hA0, 0, 0);
      push("post_rst_wait", 1, 6, 32'h60 + 32'(i), 0, 0, 0);
      chk();
    end
    drv(1, 6, 32'h63, 1, 10, 32'hA0, 0, 0);
    push("post_rst_stall", 1, 10, 32'hA0, 1, 0, 1);
    chk();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    push("post_rst_idle", 0, 0, 0, 0, 0, 0);
    chk();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit. Writeback always wins a contested cycle. A starvation counter tracks how long a pending multiply/divide result has waited. When the counter hits its limit, the block freezes the pipeline for one cycle so the result can drain. The block sits between the WB stage, the MD unit and the register file write port, and reports read-after-write hazards against the pending MD destination.

## Interface
- STARVE_LIMIT, 3, denied cycles tolerated before a forced stall; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- wb_we  in  1  writeback stage write enable.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- md_req  in  1  MD result pending; held until md_grant.
- md_addr  in  5  MD destination; stable while md_req.
- md_data  in  32  MD result; stable while md_req.
- md_grant  out  1  one-cycle pulse: MD request retired this cycle.
- rd_addr1, rd_addr2  in  5 each  decode-stage source registers.
- raw_hazard  out  1  a decode source matches the pending MD destination.
- stall  out  1  freeze all pipeline stages this cycle.
- rf_we  out  1  register file write enable.
- rf_addr  out  5  register file write address.
- rf_data  out  32  register file write data.

## Operation
- States: IDLE (no MD request waiting), WAIT (MD denied at least once), STALL (forced drain). The state is registered; the 4-bit starvation counter cnt is registered.
- wb_valid = wb_we && wb_addr != 0. md_valid = md_req && md_addr != 0.
- **Free port, IDLE or WAIT, md_req, !wb_valid:** rf_* is driven from md_*, with rf_we = md_valid. md_grant=1, next state IDLE, cnt<=0.
- **Contested port, IDLE or WAIT, md_req, wb_valid:**
  - rf_* is driven from wb_*, with rf_we=1.
  - If md_addr == wb_addr, the MD result is stale because WB is younger. md_grant=1, the MD data is discarded, next state IDLE, cnt<=0.
  - Otherwise md_grant=0 and cnt<=cnt+1. If cnt+1 == STARVE_LIMIT, next state STALL; else next state WAIT.
- **STALL:**
  - stall=1, and the WB write is suppressed; the frozen WB instruction rewrites after the stall.
  - rf_* is driven from md_*, with rf_we = md_valid. md_grant=1, next state IDLE, cnt<=0.
- **No md_req:** rf_* is driven from wb_*, with rf_we = wb_valid. Next state IDLE, cnt<=0.
- Writes to register 0 never produce rf_we=1.
- raw_hazard = md_valid && (rd_addr1 == md_addr || rd_addr2 == md_addr). It is purely combinational and independent of state.
- If md_req is deasserted in WAIT without a grant (protocol violation), the block returns to IDLE and clears cnt.

## Timing
- rf_we, rf_addr, rf_data, md_grant, raw_hazard: combinational from the inputs and the registered state. The write occurs at the same rising edge as md_grant.
- stall: a function of the registered state only, asserted for exactly one cycle per STALL entry.
- Worst-case MD latency under continuous WB writes: a request first presented in cycle 0 is granted in cycle STARVE_LIMIT.
- The MD unit must deassert md_req or present a new request in the cycle after md_grant. A request held after a grant is treated as new.
- Reset (asynchronous assert, any state including STALL): state IDLE, cnt 0, stall 0. With inputs low, rf_we 0 and md_grant 0.

## Structure
- Shared package (rf_arb_pkg):
  - state encoding IDLE=2'b00, WAIT=2'b01, STALL=2'b10;
  - REG_ZERO = 5'd0;
  - CNT_W = 4.
- One natural sub-module, rf_starve_counter: saturating increment, clear, and limit compare, producing a hit flag. All other logic is the FSM plus the write mux in the top level.

## Test plan
- **Uncontested MD:** md_req, md_addr=8, md_data=32'hDEAD0001, wb_we=0 → same cycle rf_we=1, rf_addr=8, md_grant=1; stall never asserts.
- **Starvation, STARVE_LIMIT=3:** wb_we=1 to reg 5 every cycle; md_req to reg 9 from cycle 0.
  - Cycles 0-2: writes go to reg 5, md_grant=0.
  - Cycle 3: stall=1, rf_addr=9, md_grant=1, WB write suppressed.
  - Cycle 4: state IDLE, stall=0.
- **Same-destination conflict:** wb_we=1, wb_addr=12; md_req with md_addr=12 → rf_data=wb_data, md_grant=1, no MD write in any later cycle.
- **Register 0:** md_req with md_addr=0 and wb_we=0 → md_grant=1, rf_we=0. Separately, wb_we=1 with wb_addr=0 → rf_we=0.
- **Hazard:** md_req, md_addr=17, rd_addr2=17 → raw_hazard=1. Then rd_addr1=rd_addr2=3 → raw_hazard=0.
- **Reset mid-operation:** assert reset during STALL → stall drops immediately (asynchronously); after release, cnt=0 and a new contested request takes STARVE_LIMIT cycles to force a stall.
